// File: rtl/split_tree_valve_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : split_tree_pkg
// Brief    : Shared types and helpers for the split-tree valve sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package split_tree_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PUMP  = 3'd2,
        CLOSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Heap-ordered tree: left child takes bit 0, right child takes bit 1.
    function automatic int child_idx(input int parent, input logic right);
        return 2 * parent + 1 + (right ? 1 : 0);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/split_tree_valve_seq_if.sv
//------------------------------------------------------------------------------
// Module   : split_tree_valve_seq_if
// Brief    : Request handshake plus valve/pump drive bundle.
//            SPLIT_TREE_ABORT_EN adds abort / done_aborted.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface split_tree_valve_seq_if #(
    parameter int DEPTH = 3,
    parameter int VOL_W = 8
);
    localparam int c_NODES = (2 ** DEPTH) - 1;

    logic                 req_valid;
    logic                 req_ready;
    logic [DEPTH-1:0]     req_outlet;
    logic [VOL_W-1:0]     req_vol;
    logic [c_NODES-1:0]   valve_l;
    logic [c_NODES-1:0]   valve_r;
    logic                 pump;
    logic                 busy;
    logic                 done;
    logic [DEPTH-1:0]     done_outlet;
`ifdef SPLIT_TREE_ABORT_EN
    logic                 abort;
    logic                 done_aborted;

    modport master (
        output req_valid, req_outlet, req_vol, abort,
        input  req_ready, valve_l, valve_r, pump, busy, done, done_outlet, done_aborted
    );
    modport slave (
        input  req_valid, req_outlet, req_vol, abort,
        output req_ready, valve_l, valve_r, pump, busy, done, done_outlet, done_aborted
    );
`else
    modport master (
        output req_valid, req_outlet, req_vol,
        input  req_ready, valve_l, valve_r, pump, busy, done, done_outlet
    );
    modport slave (
        input  req_valid, req_outlet, req_vol,
        output req_ready, valve_l, valve_r, pump, busy, done, done_outlet
    );
`endif

endinterface

`default_nettype wire

// File: rtl/split_tree_valve_seq_path_dec.sv
//------------------------------------------------------------------------------
// Module   : split_tree_path_dec
// Brief    : Outlet index to one-valve-per-level left/right open masks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module split_tree_path_dec
    import split_tree_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic [DEPTH-1:0]    i_outlet,
    output logic      [2**DEPTH-2:0] o_mask_l,
    output logic      [2**DEPTH-2:0] o_mask_r
);

    // Walk root to leaf, MSB of the outlet steering the root node.
    always_comb begin : p_walk
        logic [DEPTH-1:0] w_node;
        o_mask_l = '0;
        o_mask_r = '0;
        w_node   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_outlet[DEPTH-1-k]) begin
                o_mask_r[w_node] = 1'b1;
            end else begin
                o_mask_l[w_node] = 1'b1;
            end
            w_node = DEPTH'(child_idx(int'(w_node), i_outlet[DEPTH-1-k]));
        end
    end

endmodule

`default_nettype wire

// File: rtl/split_tree_valve_seq.sv
//------------------------------------------------------------------------------
// Module   : split_tree_valve_seq
// Brief    : Sequencer opening a binary split-tree valve path and metering
//            pump strokes. Optional abort path under SPLIT_TREE_ABORT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module split_tree_valve_seq
    import split_tree_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int VOL_W   = 8,
    parameter int SETTLE  = 4,
    parameter int PUMP_HI = 2,
    parameter int PUMP_LO = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    split_tree_valve_seq_if.slave  bus
);

    localparam int c_NODES   = (2 ** DEPTH) - 1;
    localparam int c_CNT_MAX = max3(SETTLE, PUMP_HI, PUMP_LO);
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0]  c_SETTLE_M1 = c_CW'(SETTLE - 1);
    localparam logic [c_CW-1:0]  c_HI_M1     = c_CW'(PUMP_HI - 1);
    localparam logic [c_CW-1:0]  c_LO_M1     = c_CW'(PUMP_LO - 1);
    localparam logic [c_CW-1:0]  c_CNT_ONE   = c_CW'(1);
    localparam logic [VOL_W-1:0] c_VOL_ONE   = VOL_W'(1);

    state_t               r_state;
    logic [c_CW-1:0]      r_cnt;
    logic [VOL_W-1:0]     r_strokes;
    logic [DEPTH-1:0]     r_outlet;
    logic [c_NODES-1:0]   r_valve_l;
    logic [c_NODES-1:0]   r_valve_r;
    logic                 r_pump;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ready;
    logic [DEPTH-1:0]     r_done_outlet;

    logic [c_NODES-1:0]   w_mask_l;
    logic [c_NODES-1:0]   w_mask_r;
    logic                 w_xfer;
    logic                 w_abort;

    split_tree_path_dec #(
        .DEPTH (DEPTH)
    ) u_path_dec (
        .i_outlet (bus.req_outlet),
        .o_mask_l (w_mask_l),
        .o_mask_r (w_mask_r)
    );

    assign w_xfer = bus.req_valid & r_ready;

`ifdef SPLIT_TREE_ABORT_EN
    logic r_aborted;
    logic r_done_aborted;

    assign w_abort          = bus.abort & ((r_state == SETUP) | (r_state == PUMP));
    assign bus.done_aborted = r_done_aborted;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_strokes     <= '0;
            r_outlet      <= '0;
            r_valve_l     <= '0;
            r_valve_r     <= '0;
            r_pump        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_ready       <= 1'b1;
            r_done_outlet <= '0;
`ifdef SPLIT_TREE_ABORT_EN
            r_aborted      <= 1'b0;
            r_done_aborted <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                // Pump stops and valves close together; CLOSE still settles fully.
                r_state   <= CLOSE;
                r_pump    <= 1'b0;
                r_valve_l <= '0;
                r_valve_r <= '0;
                r_cnt     <= c_SETTLE_M1;
`ifdef SPLIT_TREE_ABORT_EN
                r_aborted <= 1'b1;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_xfer) begin
                            r_outlet  <= bus.req_outlet;
                            r_strokes <= bus.req_vol;
                            r_ready   <= 1'b0;
                            r_busy    <= 1'b1;
`ifdef SPLIT_TREE_ABORT_EN
                            r_aborted <= 1'b0;
`endif
                            if (bus.req_vol != '0) begin
                                r_state   <= SETUP;
                                r_valve_l <= w_mask_l;
                                r_valve_r <= w_mask_r;
                                r_cnt     <= c_SETTLE_M1;
                            end else begin
                                r_state       <= DONE;
                                r_done        <= 1'b1;
                                r_done_outlet <= bus.req_outlet;
`ifdef SPLIT_TREE_ABORT_EN
                                r_done_aborted <= 1'b0;
`endif
                            end
                        end
                    end
                    SETUP: begin
                        if (r_cnt == '0) begin
                            r_state <= PUMP;
                            r_pump  <= 1'b1;
                            r_cnt   <= c_HI_M1;
                        end else begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end
                    end
                    PUMP: begin
                        // r_pump doubles as the high/low phase flag.
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end else if (r_pump) begin
                            r_pump <= 1'b0;
                            r_cnt  <= c_LO_M1;
                        end else if (r_strokes == c_VOL_ONE) begin
                            r_state   <= CLOSE;
                            r_valve_l <= '0;
                            r_valve_r <= '0;
                            r_cnt     <= c_SETTLE_M1;
                        end else begin
                            r_strokes <= r_strokes - c_VOL_ONE;
                            r_pump    <= 1'b1;
                            r_cnt     <= c_HI_M1;
                        end
                    end
                    CLOSE: begin
                        if (r_cnt == '0) begin
                            r_state       <= DONE;
                            r_done        <= 1'b1;
                            r_done_outlet <= r_outlet;
`ifdef SPLIT_TREE_ABORT_EN
                            r_done_aborted <= r_aborted;
`endif
                        end else begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_valve_l <= '0;
                        r_valve_r <= '0;
                        r_pump    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_ready   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.valve_l     = r_valve_l;
    assign bus.valve_r     = r_valve_r;
    assign bus.pump        = r_pump;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.done_outlet = r_done_outlet;

endmodule

`default_nettype wire

// File: tb/tb_split_tree_valve_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_split_tree_valve_seq
// Brief    : Directed self-checking bench for split_tree_valve_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_split_tree_valve_seq;

    localparam int c_DEPTH  = 3;
    localparam int c_VOL_W  = 8;
    localparam int c_SETTLE = 4;
    localparam int c_HI     = 2;
    localparam int c_LO     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    split_tree_valve_seq_if #(.DEPTH(c_DEPTH), .VOL_W(c_VOL_W)) bus ();

    split_tree_valve_seq #(
        .DEPTH   (c_DEPTH),
        .VOL_W   (c_VOL_W),
        .SETTLE  (c_SETTLE),
        .PUMP_HI (c_HI),
        .PUMP_LO (c_LO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // {valve_l, valve_r, pump, busy, done, req_ready}
    function automatic logic [17:0] snap();
        return {bus.valve_l, bus.valve_r, bus.pump, bus.busy, bus.done, bus.req_ready};
    endfunction

    task automatic start_req(input logic [2:0] outlet, input logic [7:0] vol);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_outlet = outlet;
        bus.req_vol    = vol;
        check_eq("ready_before_xfer", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Edge 0 has just taken the transfer; walks cycles 1..done+1 (or stop_at).
    task automatic observe(input logic [2:0] outlet, input int vol,
                           input logic [6:0] exp_l, input logic [6:0] exp_r,
                           input int stop_at);
        int p, d, rises;
        logic prev;
        logic [17:0] exp;
        logic v_on, p_on;
        p     = c_SETTLE + vol * (c_HI + c_LO);
        d     = (vol == 0) ? 1 : p + c_SETTLE + 1;
        rises = 0;
        prev  = 1'b0;
        for (int c = 1; c <= d + 1; c++) begin
            @(negedge clk);
            v_on = (vol != 0) && (c <= p);
            p_on = v_on && (c > c_SETTLE) && (((c - c_SETTLE - 1) % (c_HI + c_LO)) < c_HI);
            exp  = {v_on ? exp_l : 7'd0, v_on ? exp_r : 7'd0, p_on, (c <= d), (c == d), (c > d)};
            check_eq($sformatf("o%0d_v%0d_cyc%0d", outlet, vol, c), 32'(snap()), 32'(exp));
            if (bus.pump && !prev) rises++;
            prev = bus.pump;
            if (c == d) begin
                check_eq($sformatf("o%0d_v%0d_done_outlet", outlet, vol), 32'(bus.done_outlet), 32'(outlet));
`ifdef SPLIT_TREE_ABORT_EN
                check_eq("done_aborted_normal", 32'(bus.done_aborted), 32'd0);
`endif
            end
            if (c == stop_at) return;
        end
        check_eq($sformatf("o%0d_v%0d_strokes", outlet, vol), 32'(rises), 32'(vol));
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_outlet = '0;
        bus.req_vol    = '0;
`ifdef SPLIT_TREE_ABORT_EN
        bus.abort      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", 32'(snap()), 32'h1);
        check_eq("reset_done_outlet", 32'(bus.done_outlet), 32'd0);
`ifdef SPLIT_TREE_ABORT_EN
        check_eq("reset_done_aborted", 32'(bus.done_aborted), 32'd0);
`endif
        rst = 1'b0;

        // outlet 5 = 101: r0 -> node 2, l2 -> node 5, r5
        start_req(3'd5, 8'd3);
        observe(3'd5, 3, 7'b0000100, 7'b0100001, 0);

        start_req(3'd0, 8'd0);
        observe(3'd0, 0, 7'b0000000, 7'b0000000, 0);

        // req_valid held across both; inputs change right after the first transfer
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_outlet = 3'd7;
        bus.req_vol    = 8'd1;
        @(posedge clk);
        #1;
        bus.req_outlet = 3'd2;
        bus.req_vol    = 8'd2;
        observe(3'd7, 1, 7'b0000000, 7'b1000101, 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        observe(3'd2, 2, 7'b0010001, 7'b0000010, 0);

        // Reset in the middle of the first pump stroke of outlet 3
        start_req(3'd3, 8'd10);
        observe(3'd3, 10, 7'b0000001, 7'b0010010, 6);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_outputs", 32'(snap()), 32'h1);
        check_eq("midrst_done_outlet", 32'(bus.done_outlet), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("post_rst_idle%0d", i), 32'(snap()), 32'h1);
        end

        // Full-scale stroke count: outlet 1 = 001 -> l0, l1, r3
        start_req(3'd1, 8'd255);
        observe(3'd1, 255, 7'b0000011, 7'b0001000, 0);

`ifdef SPLIT_TREE_ABORT_EN
        // outlet 6 = 110 -> r0, r2, l6; abort sampled at end of cycle 9 (2nd stroke)
        start_req(3'd6, 8'd5);
        observe(3'd6, 5, 7'b1000000, 7'b0000101, 9);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        for (int c = 10; c <= 15; c++) begin
            @(negedge clk);
            if (c <= 13) check_eq($sformatf("abort_close%0d", c), 32'(snap()), 32'h4);
            else if (c == 14) begin
                check_eq("abort_done", 32'(snap()), 32'h6);
                check_eq("abort_done_aborted", 32'(bus.done_aborted), 32'd1);
                check_eq("abort_done_outlet", 32'(bus.done_outlet), 32'd6);
            end else check_eq("abort_ready", 32'(snap()), 32'h1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
